sort_collector: RTL and testbench
=================================

# sort_collector

Downstream stage of the 4-word sequence sorter. Captures the stream of words emitted by the comparator chain, groups every N consecutive valid words into one frame, and holds each frame in one of two ping-pong banks. Completed frames drain to the consumer over a valid/ready handshake, so the chain streams without stalling. The block also flags dropped words and frames that are not non-decreasing.

## Interface
- DW, 8: data width; matches comparator width.
- N, 4: words per frame; power of two, ≥2.
- CW, 16: width of frame counter.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DW  word from comparator chain output.
- in_valid  in  1  in_data valid this cycle; no backpressure exists upstream.
- out_data  out  DW  current frame word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  out_data is word N-1 of its frame.
- overflow  out  1  sticky; a word was dropped.
- order_err  out  1  sticky; a captured frame was not non-decreasing.
- frame_cnt  out  CW  frames fully drained, wraps modulo 2^CW.

## Operation
- One clock, asynchronous active-high reset. Clock and reset ports are `clk` and `rst`.
- Storage is two banks, B0 and B1, each N×DW. Each bank has a registered state: EMPTY, FILLING or FULL.
- Write side:
  - Registers wr_bank and wr_idx (log2 N bits).
  - Accept condition: in_valid=1 and bank[wr_bank] is not FULL. On accept:
    - store in_data at bank[wr_bank][wr_idx];
    - EMPTY→FILLING;
    - wr_idx increments.
  - On accepting index N-1:
    - bank goes FULL;
    - wr_idx wraps to 0;
    - wr_bank toggles.
  - Drop condition: in_valid=1 and bank[wr_bank] is FULL. The word is discarded and overflow is set to 1, where it stays until rst.
- Order check:
  - Register prev holds the last accepted word of the current frame.
  - An accepted word at idx>0 that is less than prev (unsigned compare) sets order_err (sticky).
  - Idx 0 never compares.
- Read side:
  - Registers rd_bank and rd_idx.
  - out_valid = (bank[rd_bank] is FULL).
  - out_data = bank[rd_bank][rd_idx].
  - out_last = out_valid and rd_idx==N-1.
  - Outputs are driven only from registered state; there is no combinational path from in_* or out_ready.
  - Transfer condition: out_valid and out_ready at an edge. rd_idx then increments.
  - On transfer of the last word:
    - bank goes EMPTY;
    - rd_idx wraps to 0;
    - rd_bank toggles;
    - frame_cnt increments (wraps).
- Simultaneous events:
  - A write and a read on different banks in the same cycle are independent.
  - A bank freed by the final read at edge k is writable only from edge k+1. A word arriving at edge k while wr_bank is still FULL is dropped, and overflow is set.
  - Write and read never target the same bank in the same cycle, because the writer never writes a FULL bank and the reader only reads FULL banks.
- Reset, asynchronous:
  - Both banks EMPTY; all pointers 0.
  - out_valid=0, out_last=0, out_data=0, overflow=0, order_err=0, frame_cnt=0.
  - A partially filled or partially drained frame is discarded. Bank contents need not be cleared, but out_data must read 0 while out_valid=0 after reset.

## Timing
- Latency: the word accepted at index N-1 at edge k produces out_valid=1 in the cycle after edge k, with out_data = word 0 of that frame.
- Throughput: 1 word/cycle in and out. Continuous input with out_ready held at 1 never overflows.
- Holding: out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Buffering: with the consumer stalled, at most 2N words are stored. Word 2N+1 is dropped.
- Sticky-flag timing: overflow and order_err rise in the cycle after the offending edge.

## Test plan
- Reset, then in = 1,3,5,7 on consecutive cycles with out_ready=1:
  - out_valid rises one cycle after word 7;
  - out emits 1,3,5,7 over 4 cycles, with out_last on 7;
  - frame_cnt=1; flags remain 0.
- Continuous 16 words 0..15 with out_ready=1:
  - 4 frames emerge in order;
  - no gaps after the first frame;
  - frame_cnt=4; overflow=0.
- out_ready=0, then 9 words 0..8:
  - words 0–7 are stored and word 8 is dropped; overflow=1 the next cycle;
  - after raising out_ready, output is 0..7 and frame_cnt=2.
- Frame 4,2,6,8:
  - order_err=1 one cycle after word 2 is accepted;
  - the frame is still emitted unchanged.
- Both banks FULL; the last word of B0 is drained at the same edge a new word arrives:
  - that word is dropped and overflow=1;
  - the next word is written to B0 at idx 0.
- Assert rst mid-frame, after 2 of 4 words:
  - all outputs are 0 immediately (asynchronous);
  - a subsequent clean 4-word frame is emitted correctly with frame_cnt=1.

Source files
------------

// File: rtl/sort_collector.sv
`default_nettype none
// ============================================================================
// Module   : sort_collector
// Brief    : Groups N-word frames from the sorter chain into two ping-pong
//            banks, drains them over valid/ready, flags drops and disorder.
// Revision : 1.0
// ============================================================================
module sort_collector #(
   parameter int DW = 8,
   parameter int N  = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          overflow,
   output logic          order_err,
   output logic [CW-1:0] frame_cnt
);

   localparam int            c_IW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(N - 1);

   localparam logic [1:0] c_EMPTY   = 2'd0;
   localparam logic [1:0] c_FILLING = 2'd1;
   localparam logic [1:0] c_FULL    = 2'd2;

   logic [DW-1:0]   r_mem [2][N];
   logic [1:0]      r_state [2];
   logic [1:0]      w_state_nxt [2];

   logic            r_wr_bank;
   logic [c_IW-1:0] r_wr_idx;
   logic            r_rd_bank;
   logic [c_IW-1:0] r_rd_idx;
   logic [DW-1:0]   r_prev;
   logic            r_overflow;
   logic            r_order_err;
   logic [CW-1:0]   r_frame_cnt;

   logic            w_wr_full;
   logic            w_accept;
   logic            w_drop;
   logic            w_wr_last;
   logic            w_order_bad;
   logic            w_rd_valid;
   logic            w_xfer;
   logic            w_rd_last;

   // Every decision is taken from pre-edge bank state, so a bank freed by
   // the final read at this edge is still seen as FULL by the writer.
   assign w_wr_full   = (r_state[r_wr_bank] == c_FULL);
   assign w_accept    = in_valid && !w_wr_full;
   assign w_drop      = in_valid && w_wr_full;
   assign w_wr_last   = (r_wr_idx == c_LAST_IDX);
   assign w_order_bad = w_accept && (r_wr_idx != '0) && (in_data < r_prev);

   assign w_rd_valid  = (r_state[r_rd_bank] == c_FULL);
   assign w_xfer      = w_rd_valid && out_ready;
   assign w_rd_last   = (r_rd_idx == c_LAST_IDX);

   // Bank state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state[0] <= c_EMPTY;
         r_state[1] <= c_EMPTY;
      end else begin
         r_state[0] <= w_state_nxt[0];
         r_state[1] <= w_state_nxt[1];
      end
   end

   // Bank next-state logic
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         w_state_nxt[b] = r_state[b];
         if (w_accept && (r_wr_bank == 1'(b))) begin
            w_state_nxt[b] = w_wr_last ? c_FULL : c_FILLING;
         end
         if (w_xfer && w_rd_last && (r_rd_bank == 1'(b))) begin
            w_state_nxt[b] = c_EMPTY;
         end
      end
   end

   // Output logic; data is masked so stale bank contents never leak out
   always_comb begin
      out_valid = w_rd_valid;
      out_data  = w_rd_valid ? r_mem[r_rd_bank][r_rd_idx] : '0;
      out_last  = w_rd_valid && w_rd_last;
      overflow  = r_overflow;
      order_err = r_order_err;
      frame_cnt = r_frame_cnt;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_bank][r_wr_idx] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank   <= 1'b0;
         r_wr_idx    <= '0;
         r_prev      <= '0;
         r_overflow  <= 1'b0;
         r_order_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_prev   <= in_data;
            r_wr_idx <= w_wr_last ? '0 : r_wr_idx + c_IW'(1);
            if (w_wr_last) begin
               r_wr_bank <= ~r_wr_bank;
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_order_bad) begin
            r_order_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_bank   <= 1'b0;
         r_rd_idx    <= '0;
         r_frame_cnt <= '0;
      end else if (w_xfer) begin
         r_rd_idx <= w_rd_last ? '0 : r_rd_idx + c_IW'(1);
         if (w_rd_last) begin
            r_rd_bank   <= ~r_rd_bank;
            r_frame_cnt <= r_frame_cnt + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sort_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_collector
// Brief    : Directed bench for sort_collector with a queue-level frame model.
// Revision : 1.0
// ============================================================================
module tb_sort_collector;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          overflow;
   logic          order_err;
   logic [CW-1:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int cycle = 0;

   sort_collector #(.DW(DW), .N(N), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .overflow  (overflow),
      .order_err (order_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame model: m_fq holds undrained words of complete frames, m_pq the
   // frame being collected. Two banks hold at most two frames in total.
   logic [DW-1:0] m_fq[$];
   logic [DW-1:0] m_pq[$];
   logic          m_ovf;
   logic          m_oerr;
   logic [CW-1:0] m_fcnt;
   int            m_nfull;
   bit            m_do_rd;
   bit            m_rd_last;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fq.delete();
         m_pq.delete();
         m_ovf  = 1'b0;
         m_oerr = 1'b0;
         m_fcnt = '0;
      end else begin
         m_nfull   = (m_fq.size() + N - 1) / N;
         m_do_rd   = (m_fq.size() > 0) && out_ready;
         m_rd_last = (m_fq.size() % N) == 1;
         if (in_valid) begin
            if (m_pq.size() > 0 || m_nfull < 2) begin
               if (m_pq.size() > 0 && in_data < m_pq[$]) m_oerr = 1'b1;
               m_pq.push_back(in_data);
               if (m_pq.size() == N) begin
                  foreach (m_pq[i]) m_fq.push_back(m_pq[i]);
                  m_pq.delete();
               end
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (m_do_rd) begin
            void'(m_fq.pop_front());
            if (m_rd_last) m_fcnt = m_fcnt + CW'(1);
         end
      end
   end

   // Per-cycle comparison against the model, plus capture of transfers
   logic [DW-1:0] got[$];
   int            got_t[$];
   logic          e_valid;
   logic [DW-1:0] e_data;
   logic          e_last;

   always @(negedge clk) begin
      e_valid = m_fq.size() > 0;
      e_data  = e_valid ? m_fq[0] : '0;
      e_last  = e_valid && ((m_fq.size() % N) == 1);
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_data",  32'(out_data),  32'(e_data));
      chk("out_last",  32'(out_last),  32'(e_last));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("order_err", 32'(order_err), 32'(m_oerr));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      if (!rst && out_valid && out_ready) begin
         got.push_back(out_data);
         got_t.push_back(cycle);
      end
   end

   logic [DW-1:0] exp_q[$];

   task automatic cyc(input logic v, input int d, input logic rdy);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = DW'(d);
      out_ready = rdy;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, rdy);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      got_t.delete();
      exp_q.delete();
   endtask

   task automatic check_got(input string nm);
      chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk(nm, 32'(got[i]), 32'(exp_q[i]));
   endtask

   initial begin
      do_reset();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data",  32'(out_data),  0);
      chk("rst_fcnt",  32'(frame_cnt), 0);
      chk("rst_ovf",   32'(overflow),  0);

      // Single ordered frame, consumer ready
      cyc(1, 1, 1); cyc(1, 3, 1); cyc(1, 5, 1); cyc(1, 7, 1);
      chk("t1_valid_early", 32'(out_valid), 0);
      cyc(0, 0, 1);
      chk("t1_valid_lat", 32'(out_valid), 1);
      chk("t1_first_data", 32'(out_data), 1);
      idle(6, 1);
      for (int i = 0; i < 4; i++) exp_q.push_back(DW'(2 * i + 1));
      check_got("t1_out");
      chk("t1_fcnt", 32'(frame_cnt), 1);
      chk("t1_ovf",  32'(overflow),  0);
      chk("t1_oerr", 32'(order_err), 0);

      // Continuous stream of 16 words
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1, i, 1);
      idle(8, 1);
      for (int i = 0; i < 16; i++) exp_q.push_back(DW'(i));
      check_got("t2_out");
      if (got_t.size() == 16) chk("t2_no_gaps", 32'(got_t[15] - got_t[0]), 15);
      else chk("t2_no_gaps", 32'(got_t.size()), 16);
      chk("t2_fcnt", 32'(frame_cnt), 4);
      chk("t2_ovf",  32'(overflow),  0);

      // Stalled consumer: 9th word is dropped
      do_reset();
      for (int i = 0; i < 9; i++) cyc(1, i, 0);
      chk("t3_ovf_before", 32'(overflow), 0);
      cyc(0, 0, 0);
      chk("t3_ovf_after", 32'(overflow), 1);
      chk("t3_hold_data", 32'(out_data), 0);
      idle(12, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i));
      check_got("t3_out");
      chk("t3_fcnt", 32'(frame_cnt), 2);

      // Out-of-order frame still emitted unchanged
      do_reset();
      cyc(1, 4, 1); cyc(1, 2, 1);
      chk("t4_oerr_before", 32'(order_err), 0);
      cyc(1, 6, 1);
      chk("t4_oerr_after", 32'(order_err), 1);
      cyc(1, 8, 1);
      idle(6, 1);
      exp_q.push_back(8'd4); exp_q.push_back(8'd2);
      exp_q.push_back(8'd6); exp_q.push_back(8'd8);
      check_got("t4_out");

      // Word arriving at the edge that frees B0 is dropped
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 10 + i, 0);
      cyc(0, 0, 0);
      chk("t5_hold_data", 32'(out_data), 10);
      cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
      cyc(1, 99, 1);
      chk("t5_ovf_before", 32'(overflow), 0);
      cyc(1, 50, 1);
      chk("t5_ovf_after", 32'(overflow), 1);
      cyc(1, 51, 1); cyc(1, 52, 1); cyc(1, 53, 1);
      idle(12, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(DW'(10 + i));
      for (int i = 0; i < 4; i++) exp_q.push_back(DW'(50 + i));
      check_got("t5_out");
      chk("t5_fcnt", 32'(frame_cnt), 3);

      // Asynchronous reset mid-frame
      do_reset();
      for (int i = 1; i <= 4; i++) cyc(1, i, 1);
      idle(5, 1);
      for (int i = 11; i <= 16; i++) cyc(1, i, 0);
      cyc(0, 0, 0);
      chk("t6_pre_valid", 32'(out_valid), 1);
      chk("t6_pre_fcnt",  32'(frame_cnt), 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(out_valid), 0);
      chk("t6_async_data",  32'(out_data),  0);
      chk("t6_async_last",  32'(out_last),  0);
      chk("t6_async_fcnt",  32'(frame_cnt), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      got_t.delete();
      exp_q.delete();
      for (int i = 30; i <= 33; i++) cyc(1, i, 1);
      idle(8, 1);
      for (int i = 30; i <= 33; i++) exp_q.push_back(DW'(i));
      check_got("t6_out");
      chk("t6_fcnt", 32'(frame_cnt), 1);
      chk("t6_ovf",  32'(overflow),  0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
